cpu_fabric_bridge: RTL and testbench

- CPU-side custom-instruction bridge. It sits directly upstream and downstream of the east-edge CPU IO tiles.
- Accepts a 2-operand request from the CPU over a valid/ready handshake.
- Drives the operands nibble-wise onto the tiles' OPA/OPB inputs, then waits for a fixed latency or a fabric "done" flag.
- Captures the RES0/RES1/RES2 outputs and returns them to the CPU over a valid/ready response handshake.

---
 rtl/cpu_fabric_bridge_pkg.sv | 20 ++
 rtl/cpu_fabric_bridge_cnt.sv | 34 +++
 rtl/cpu_fabric_bridge.sv | 141 ++++++++++++++
 tb/tb_cpu_fabric_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fabric_bridge_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_fabric_bridge_pkg : shared types and constants for the bridge    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_fabric_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;
    localparam int DONE_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/cpu_fabric_bridge_cnt.sv
// +----------------------------------------------------------------------+
// | cpu_fabric_bridge_cnt : loadable saturating down-counter, zero flag  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module cpu_fabric_bridge_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/cpu_fabric_bridge.sv
// +----------------------------------------------------------------------+
// | cpu_fabric_bridge : CPU custom-instruction bridge to east-edge tiles |
// | Optional: CPU_FABRIC_BRIDGE_TIMEOUT_EN adds a done-mode timeout.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module cpu_fabric_bridge
    import cpu_fabric_bridge_pkg::*;
#(
    parameter int NUM_TILES      = 8,
    parameter int LAT_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          UserCLK,
    input  logic                          reset,
    input  logic [LAT_W-1:0]              cfg_latency,
    input  logic                          cfg_use_done,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [NIBBLE_W*NUM_TILES-1:0] req_op_a,
    input  logic [NIBBLE_W*NUM_TILES-1:0] req_op_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [NIBBLE_W*NUM_TILES-1:0] rsp_res0,
    output logic [NIBBLE_W*NUM_TILES-1:0] rsp_res1,
    output logic [NIBBLE_W*NUM_TILES-1:0] rsp_res2,
    output logic                          rsp_timeout,
    output logic [NIBBLE_W*NUM_TILES-1:0] fab_opa,
    output logic [NIBBLE_W*NUM_TILES-1:0] fab_opb,
    input  logic [NIBBLE_W*NUM_TILES-1:0] fab_res0,
    input  logic [NIBBLE_W*NUM_TILES-1:0] fab_res1,
    input  logic [NIBBLE_W*NUM_TILES-1:0] fab_res2,
    output logic                          busy
);

    state_t state;
    logic   use_done;
    logic   accept;
    logic   lat_zero;
    logic   lat_hit;
    logic   done_hit;
    logic   to_hit;

    // Held low during reset so the CPU never sees a ready it cannot use.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    cpu_fabric_bridge_cnt #(
        .WIDTH (LAT_W)
    ) u_lat_cnt (
        .clk      (UserCLK),
        .rst      (reset),
        .load     (accept),
        .load_val (cfg_latency),
        .dec      ((state == WAIT) && !use_done),
        .zero     (lat_zero)
    );

    assign lat_hit  = !use_done && lat_zero;
    assign done_hit = use_done && fab_res2[DONE_BIT];

`ifdef CPU_FABRIC_BRIDGE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Loaded one short so the capture lands after exactly TIMEOUT_CYCLES WAIT cycles.
    localparam logic [TO_W-1:0] TO_LOAD =
        (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    logic to_zero;

    cpu_fabric_bridge_cnt #(
        .WIDTH (TO_W)
    ) u_to_cnt (
        .clk      (UserCLK),
        .rst      (reset),
        .load     (accept),
        .load_val (TO_LOAD),
        .dec      ((state == WAIT) && use_done),
        .zero     (to_zero)
    );

    assign to_hit = use_done && to_zero && !fab_res2[DONE_BIT];
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign to_hit             = 1'b0;
`endif

    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            use_done    <= 1'b0;
            fab_opa     <= '0;
            fab_opb     <= '0;
            rsp_res0    <= '0;
            rsp_res1    <= '0;
            rsp_res2    <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fab_opa     <= req_op_a;
                        fab_opb     <= req_op_b;
                        use_done    <= cfg_use_done;
                        rsp_timeout <= 1'b0;
                        busy        <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_hit || done_hit || to_hit) begin
                        rsp_res0    <= fab_res0;
                        rsp_res1    <= fab_res1;
                        rsp_res2    <= fab_res2;
                        rsp_timeout <= to_hit;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_fabric_bridge.sv
// +----------------------------------------------------------------------+
// | tb_cpu_fabric_bridge : directed self-checking bench for the bridge   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cpu_fabric_bridge;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    cfg_latency = '0;
    logic          cfg_use_done = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_op_a = '0;
    logic [DW-1:0] req_op_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_res0, rsp_res1, rsp_res2;
    logic          rsp_timeout;
    logic [DW-1:0] fab_opa, fab_opb;
    logic [DW-1:0] fab_res0, fab_res1, fab_res2;
    logic          busy;

    logic          done_flag = 1'b0;
    logic          res0_ovr = 1'b0;
    logic [DW-1:0] res0_ovr_val = '0;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] held;

    // Tile model: adder on RES0, xor on RES1, fixed pattern plus done flag on RES2.
    assign fab_res0 = res0_ovr ? res0_ovr_val : (fab_opa + fab_opb);
    assign fab_res1 = fab_opa ^ fab_opb;
    assign fab_res2 = {28'hABCDEF0, 3'b101, done_flag};

    always #5 clk = ~clk;

    cpu_fabric_bridge #(
        .NUM_TILES      (8),
        .LAT_W          (4),
        .TIMEOUT_CYCLES (5)
    ) dut (
        .UserCLK      (clk),
        .reset        (reset),
        .cfg_latency  (cfg_latency),
        .cfg_use_done (cfg_use_done),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op_a     (req_op_a),
        .req_op_b     (req_op_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_res0     (rsp_res0),
        .rsp_res1     (rsp_res1),
        .rsp_res2     (rsp_res2),
        .rsp_timeout  (rsp_timeout),
        .fab_opa      (fab_opa),
        .fab_opb      (fab_opb),
        .fab_res0     (fab_res0),
        .fab_res1     (fab_res1),
        .fab_res2     (fab_res2),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] lat, input logic use_done,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        cfg_latency  = lat;
        cfg_use_done = use_done;
        req_op_a     = a;
        req_op_b     = b;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fab_opa",   fab_opa,   0);
        check("rst_busy",      busy,      0);
        @(negedge clk) reset = 1'b0;
        #1 check("rel_req_ready", req_ready, 1);

        // Latency 3: response 4 edges after accept.
        issue(4'd3, 1'b0, 32'h12345678, 32'h9ABCDEF0);
        check("lat_fab_opa",   fab_opa,   32'h12345678);
        check("lat_fab_opb",   fab_opb,   32'h9ABCDEF0);
        check("lat_req_ready", req_ready, 0);
        check("lat_busy",      busy,      1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("lat_wait%0d", i), rsp_valid, 0);
        end
        tick();
        check("lat_rsp_valid",   rsp_valid,   1);
        check("lat_rsp_res0",    rsp_res0,    32'hACF13568);
        check("lat_rsp_res1",    rsp_res1,    32'h88888888);
        check("lat_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        tick();
        check("lat_done_valid", rsp_valid, 0);
        check("lat_done_ready", req_ready, 1);
        check("lat_opa_kept",   fab_opa,   32'h12345678);

        // Latency 0 back-to-back, rsp_ready held high: one response per 3 cycles.
        begin
            logic [DW-1:0] va [3];
            logic [DW-1:0] vb [3];
            logic [DW-1:0] vs [3];
            va[0] = 32'h00000001; vb[0] = 32'h00000002; vs[0] = 32'h00000003;
            va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000001; vs[1] = 32'h00000000;
            va[2] = 32'h11111111; vb[2] = 32'h22222222; vs[2] = 32'h33333333;
            cfg_latency  = 4'd0;
            cfg_use_done = 1'b0;
            req_valid    = 1'b1;
            for (int i = 0; i < 3; i++) begin
                req_op_a = va[i];
                req_op_b = vb[i];
                tick();
                check($sformatf("b2b%0d_wait_ready", i), req_ready, 0);
                check($sformatf("b2b%0d_wait_valid", i), rsp_valid, 0);
                req_op_a = 32'hDEADBEEF;
                tick();
                check($sformatf("b2b%0d_valid", i), rsp_valid, 1);
                check($sformatf("b2b%0d_res0", i),  rsp_res0,  vs[i]);
                check($sformatf("b2b%0d_resp_ready", i), req_ready, 0);
                tick();
                check($sformatf("b2b%0d_idle_valid", i), rsp_valid, 0);
                check($sformatf("b2b%0d_idle_ready", i), req_ready, 1);
            end
            req_valid = 1'b0;
        end

        // Done mode: flag raised after edge accept+7, captured on edge accept+8.
        issue(4'd0, 1'b1, 32'h00000010, 32'h00000020);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("done_wait%0d", i), rsp_valid, 0);
        end
        done_flag = 1'b1;
        tick();
        check("done_valid",   rsp_valid,   1);
        check("done_timeout", rsp_timeout, 0);
        check("done_res2",    rsp_res2,    32'hABCDEF0B);
        check("done_res0",    rsp_res0,    32'h00000030);
        tick();
        check("done_back_idle", req_ready, 1);

        // Done flag already high: honoured in the first WAIT cycle.
        issue(4'd9, 1'b1, 32'h00000005, 32'h00000006);
        tick();
        check("done_early_valid", rsp_valid, 1);
        check("done_early_res0",  rsp_res0,  32'h0000000B);
        tick();
        done_flag = 1'b0;

        // Backpressure: response held while fabric output toggles.
        rsp_ready = 1'b0;
        issue(4'd1, 1'b0, 32'h000000F0, 32'h0000000F);
        tick();
        tick();
        check("bp_valid", rsp_valid, 1);
        held = rsp_res0;
        check("bp_res0", held, 32'h000000FF);
        res0_ovr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            res0_ovr_val = (i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
            tick();
            check($sformatf("bp%0d_res0", i),  rsp_res0,  32'h000000FF);
            check($sformatf("bp%0d_ready", i), req_ready, 0);
            check($sformatf("bp%0d_valid", i), rsp_valid, 1);
        end
        res0_ovr  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_release", rsp_valid, 0);

        // Reset in WAIT aborts without a response.
        issue(4'd5, 1'b0, 32'h01010101, 32'h02020202);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_opa",   fab_opa,   0);
        check("mid_rst_res0",  rsp_res0,  0);
        check("mid_rst_busy",  busy,      0);
        check("mid_rst_ready", req_ready, 0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("post_rst%0d_valid", i), rsp_valid, 0);
        end
        issue(4'd2, 1'b0, 32'h01010101, 32'h02020202);
        tick();
        tick();
        check("post_rst_early", rsp_valid, 0);
        tick();
        check("post_rst_valid", rsp_valid, 1);
        check("post_rst_res0",  rsp_res0,  32'h03030303);
        tick();

`ifdef CPU_FABRIC_BRIDGE_TIMEOUT_EN
        // Timeout: flag never set, forced response after 5 WAIT cycles.
        issue(4'd0, 1'b1, 32'h00000001, 32'h00000001);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("to_wait%0d", i), rsp_valid, 0);
        end
        tick();
        check("to_valid",   rsp_valid,   1);
        check("to_flag",    rsp_timeout, 1);
        check("to_res0",    rsp_res0,    32'h00000002);
        tick();
        issue(4'd0, 1'b0, 32'h0, 32'h0);
        check("to_cleared", rsp_timeout, 0);
        tick();
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
